// File: rtl/aes_round_sequencer.sv
// Multi-cycle AES block sequencer: drives the shared combinational round datapath
// once per cycle, streams round keys from a 1-cycle-latency store, returns the block on valid/ready.
module aes_round_sequencer #(
    parameter int DATA_W    = 128,
    parameter int RK_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 start_ready,
    input  logic [DATA_W-1:0]    block_in,
    input  logic                 encrypt_in,
    input  logic [1:0]           key_size,
    output logic [RK_ADDR_W-1:0] rk_addr,
    input  logic [DATA_W-1:0]    rk_data,
    output logic [DATA_W-1:0]    aes_A,
    output logic [DATA_W-1:0]    aes_B,
    output logic                 aes_encryption,
    output logic                 aes_finalRound,
    output logic                 aes_keyAssist,
    input  logic [DATA_W-1:0]    aes_result,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [3:0]           round_cnt
);

    // Handshakes: start is taken on a cycle with start && start_ready; the result
    // is consumed on a cycle with out_valid && out_ready, and out_valid/out_data hold until then.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_INIT,
        S_ROUND,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [DATA_W-1:0]      blk_q;
    logic [DATA_W-1:0]      out_data_q;
    logic                   enc_q;
    logic [3:0]             nr_q;
    logic [3:0]             nr_d;
    logic [3:0]             round_q;
    logic [RK_ADDR_W-1:0]   rk_addr_q;
    logic [RK_ADDR_W-1:0]   rk_addr_d;
    logic                   start_ready_q;
    logic                   busy_q;
    logic                   out_valid_q;
    logic                   in_round;

    always_comb begin
        case (key_size)
            2'd1:    nr_d = 4'd12;
            2'd2:    nr_d = 4'd14;
            default: nr_d = 4'd10;
        endcase
    end

    // Key address walks one step per cycle and saturates at the end of the schedule,
    // so the prefetch issued during the final round stays inside the store.
    always_comb begin
        rk_addr_d = rk_addr_q;
        if (enc_q) begin
            if (rk_addr_q != RK_ADDR_W'(nr_q)) begin
                rk_addr_d = rk_addr_q + RK_ADDR_W'(1);
            end
        end else if (rk_addr_q != '0) begin
            rk_addr_d = rk_addr_q - RK_ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            blk_q         <= '0;
            out_data_q    <= '0;
            enc_q         <= 1'b0;
            nr_q          <= 4'd10;
            round_q       <= 4'd0;
            rk_addr_q     <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        blk_q         <= block_in;
                        enc_q         <= encrypt_in;
                        nr_q          <= nr_d;
                        rk_addr_q     <= encrypt_in ? '0 : RK_ADDR_W'(nr_d);
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rk_addr_q <= rk_addr_d;
                    state_q   <= S_INIT;
                end
                S_INIT: begin
                    blk_q     <= blk_q ^ rk_data;
                    round_q   <= 4'd1;
                    rk_addr_q <= rk_addr_d;
                    state_q   <= S_ROUND;
                end
                S_ROUND: begin
                    blk_q     <= aes_result;
                    rk_addr_q <= rk_addr_d;
                    if (round_q == nr_q) begin
                        round_q     <= 4'd0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= aes_result;
                        state_q     <= S_DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        rk_addr_q     <= '0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The round datapath is combinational, so its operands must follow the
    // live state register and the key arriving this cycle.
    assign in_round       = (state_q == S_ROUND);
    assign aes_A          = in_round ? blk_q : '0;
    assign aes_B          = in_round ? rk_data : '0;
    assign aes_encryption = in_round & enc_q;
    assign aes_finalRound = in_round && (round_q == nr_q);
    assign aes_keyAssist  = 1'b0;

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign rk_addr     = rk_addr_q;
    assign round_cnt   = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES round datapath and round-key store
// around the DUT, FIPS-197 known-answer blocks as expected results.
module tb_aes_round_sequencer;

    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk;
    logic         reset;
    logic         start;
    logic         start_ready;
    logic [127:0] block_in;
    logic         encrypt_in;
    logic [1:0]   key_size;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic [127:0] aes_A;
    logic [127:0] aes_B;
    logic         aes_encryption;
    logic         aes_finalRound;
    logic         aes_keyAssist;
    logic [127:0] aes_result;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic         busy;
    logic [3:0]   round_cnt;

    logic [127:0] rk_mem [0:14];
    logic [127:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    aes_round_sequencer #(.DATA_W(128), .RK_ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
        .block_in(block_in), .encrypt_in(encrypt_in), .key_size(key_size),
        .rk_addr(rk_addr), .rk_data(rk_data), .aes_A(aes_A), .aes_B(aes_B),
        .aes_encryption(aes_encryption), .aes_finalRound(aes_finalRound),
        .aes_keyAssist(aes_keyAssist), .aes_result(aes_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .round_cnt(round_cnt)
    );

    // ---------------- clock and key store ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rk_data <= (rk_addr <= 4'd14) ? rk_mem[rk_addr] : 'x;
    end

    // ---------------- AES reference round ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] l;
        logic [7:0] r;
        l = b << n;
        r = b >> (8 - n);
        return l | r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[8*(15-i) +: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = inv ? inv_sbox(gb(s, i)) : sbox(gb(s, i));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[8*(15-(r+4*c)) +: 8] = gb(s, r + 4*src);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j-i)&3], gb(s, 4*c+j));
                o[8*(15-(4*c+i)) +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_rnd(input logic [127:0] a, input logic [127:0] k,
                                             input logic enc, input logic fin);
        logic [127:0] t;
        t = enc ? shift_rows(sub_bytes(a, 1'b0), 1'b0) : shift_rows(sub_bytes(a, 1'b1), 1'b1);
        if (!fin) t = mix_cols(t, !enc);
        return t ^ k;
    endfunction

    assign aes_result = aes_rnd(aes_A, aes_B, aes_encryption, aes_finalRound);

    // Fills the store with the forward schedule, or the equivalent-inverse schedule for decryption.
    task automatic load_keys(input logic [255:0] key, input int nk, input bit dec);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] rk;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 15; j++) begin
            rk_mem[j] = '0;
            if (j <= nr) begin
                rk = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
                rk_mem[j] = (dec && j != 0 && j != nr) ? mix_cols(rk, 1'b1) : rk;
            end
        end
    endtask

    // ---------------- driver / scoreboard tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [127:0] blk, input bit enc, input logic [1:0] ks,
                            input logic [127:0] exp);
        check("start_ready before accept", 128'(start_ready), 128'(1));
        start      = 1'b1;
        block_in   = blk;
        encrypt_in = enc;
        key_size   = ks;
        exp_q.push_back(exp);
        tick;
        start = 1'b0;
        check("busy after accept", 128'(busy), 128'(1));
    endtask

    // Walks the operation cycle by cycle from FETCH (k=1); inputs are scrambled every cycle.
    task automatic follow_op(input bit enc, input int nr, input int hold);
        int           k;
        int           r;
        int           ea;
        int           prev_ea;
        bit           got;
        bit           in_rnd;
        logic [127:0] exp;
        exp = '0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        k = 1;
        got = 1'b0;
        prev_ea = 0;
        while (!got && k <= 40) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                r = k - 2;
                in_rnd = (k >= 3) && (k <= nr + 2);
                ea = enc ? ((k - 1 < nr) ? k - 1 : nr) : ((nr - k + 1 > 0) ? nr - k + 1 : 0);
                check($sformatf("rk_addr k=%0d", k), 128'(rk_addr), 128'(ea));
                check($sformatf("round_cnt k=%0d", k), 128'(round_cnt), in_rnd ? 128'(r) : 128'(0));
                check($sformatf("finalRound k=%0d", k), 128'(aes_finalRound), 128'(in_rnd && r == nr));
                check($sformatf("aes_encryption k=%0d", k), 128'(aes_encryption), 128'(in_rnd && enc));
                check($sformatf("busy k=%0d", k), 128'(busy), 128'(1));
                check($sformatf("start_ready k=%0d", k), 128'(start_ready), 128'(0));
                check($sformatf("keyAssist k=%0d", k), 128'(aes_keyAssist), 128'(0));
                if (in_rnd) begin
                    check($sformatf("aes_B key k=%0d", k), aes_B, rk_mem[prev_ea]);
                end else begin
                    check($sformatf("aes_A idle k=%0d", k), aes_A, 128'(0));
                end
                prev_ea    = ea;
                start      = 1'($urandom_range(0, 1));
                block_in   = {$urandom, $urandom, $urandom, $urandom};
                encrypt_in = 1'($urandom_range(0, 1));
                key_size   = 2'($urandom_range(0, 3));
                tick;
                k++;
            end
        end
        start = 1'b0;
        check("out_valid seen", 128'(got), 128'(1));
        check("latency", 128'(k), 128'(nr + 3));
        check("out_data", out_data, exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            block_in  = {$urandom, $urandom, $urandom, $urandom};
            tick;
            check($sformatf("hold valid h=%0d", h), 128'(out_valid), 128'(1));
            check($sformatf("hold data h=%0d", h), out_data, exp);
            check($sformatf("hold start_ready h=%0d", h), 128'(start_ready), 128'(0));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        tick;
        start = 1'b0;
        check("out_valid dropped", 128'(out_valid), 128'(0));
        check("idle after handshake", 128'(start_ready), 128'(1));
        check("not busy after handshake", 128'(busy), 128'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " start_ready"}, 128'(start_ready), 128'(1));
        check({tag, " busy"}, 128'(busy), 128'(0));
        check({tag, " out_valid"}, 128'(out_valid), 128'(0));
        check({tag, " rk_addr"}, 128'(rk_addr), 128'(0));
        check({tag, " round_cnt"}, 128'(round_cnt), 128'(0));
        check({tag, " aes_A"}, aes_A, 128'(0));
        check({tag, " aes_B"}, aes_B, 128'(0));
        check({tag, " aes_encryption"}, 128'(aes_encryption), 128'(0));
        check({tag, " aes_finalRound"}, 128'(aes_finalRound), 128'(0));
        check({tag, " aes_keyAssist"}, 128'(aes_keyAssist), 128'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        reset      = 1'b1;
        start      = 1'b0;
        block_in   = '0;
        encrypt_in = 1'b0;
        key_size   = 2'd0;
        out_ready  = 1'b1;
        load_keys(K128, 4, 1'b0);
        tick;
        tick;
        check_idle_outputs("reset");
        check("reset out_data", out_data, 128'(0));
        reset = 1'b0;
        tick;
        check_idle_outputs("post-reset");

        start_op(PT, 1'b1, 2'd0, C128);
        follow_op(1'b1, 10, 0);

        load_keys(K128, 4, 1'b1);
        start_op(C128, 1'b0, 2'd0, PT);
        follow_op(1'b0, 10, 0);

        load_keys(K192, 6, 1'b0);
        start_op(PT, 1'b1, 2'd1, C192);
        follow_op(1'b1, 12, 0);

        load_keys(K256, 8, 1'b0);
        start_op(PT, 1'b1, 2'd2, C256);
        follow_op(1'b1, 14, 0);

        load_keys(K128, 4, 1'b0);
        start_op(PT, 1'b1, 2'd3, C128);
        follow_op(1'b1, 10, 0);

        out_ready = 1'b0;
        start_op(PT, 1'b1, 2'd0, C128);
        follow_op(1'b1, 10, 20);
        start_op(PT, 1'b1, 2'd0, C128);
        follow_op(1'b1, 10, 0);

        start_op(PT, 1'b1, 2'd0, C128);
        k = 0;
        while (round_cnt !== 4'd5 && k < 20) begin
            tick;
            k++;
        end
        check("reached round 5", 128'(round_cnt), 128'(5));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_q.delete();
        check_idle_outputs("mid-op reset");
        for (int i = 0; i < 16; i++) begin
            tick;
            check($sformatf("no stale valid i=%0d", i), 128'(out_valid), 128'(0));
        end
        start_op(PT, 1'b1, 2'd0, C128);
        follow_op(1'b1, 10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Multi-cycle controller that runs one AES block encryption or decryption by driving the shared combinational AES round datapath (the aes unit inside the exec stage) once per cycle. It fetches round keys from the round-key store through a 1-cycle-latency read port and holds the running cipher state. It hands the finished block back over a valid/ready handshake. It sits beside the exec stage and owns the AES operand/control lines while busy.

Parameters:
DATA_W, 128, block/state/round-key width
RK_ADDR_W, 4, round-key store address width (indices 0..14)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  request a block operation; accepted only when start_ready=1
start_ready  out  1  high in IDLE only
block_in  in  DATA_W  plaintext/ciphertext, sampled on accept
encrypt_in  in  1  1=encrypt, 0=decrypt, sampled on accept
key_size  in  2  0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=reserved (treated as 0); sampled on accept
rk_addr  out  RK_ADDR_W  round-key read address
rk_data  in  DATA_W  round key for the address presented the previous cycle
aes_A  out  DATA_W  state operand to the AES round datapath
aes_B  out  DATA_W  round-key operand to the AES round datapath
aes_encryption  out  1  direction to the AES datapath
aes_finalRound  out  1  final round select (no MixColumns)
aes_keyAssist  out  1  always 0 from this block
aes_result  in  DATA_W  combinational round output
out_valid  out  1  result available
out_data  out  DATA_W  result block
out_ready  in  1  consumer accepts the result
busy  out  1  high in any state other than IDLE
round_cnt  out  4  current round number (debug), 0 outside ROUND

Behaviour:
- Reset, synchronous, overrides everything including mid-operation: state -> IDLE. start_ready=1; out_valid=0, out_data=0, busy=0, rk_addr=0, round_cnt=0. aes_A/aes_B=0, aes_encryption=0, aes_finalRound=0, aes_keyAssist=0. Any in-flight block is discarded; no out_valid for it.
- States: IDLE, FETCH, INIT, ROUND, DONE.
- IDLE: on start=1, latch block_in, encrypt_in and Nr. Drive rk_addr = encrypt ? 0 : Nr. Go to FETCH.
- FETCH: wait one cycle for rk_data. Drive rk_addr to the next key: encrypt ? 1 : Nr-1. Go to INIT.
- INIT: state_reg <= block ^ rk_data (initial AddRoundKey). r <= 1. rk_addr advances by one key in the same direction. Go to ROUND.
- ROUND, round r = 1..Nr:
  - Drive aes_A=state_reg, aes_B=rk_data, aes_encryption=latched mode, aes_finalRound=(r==Nr).
  - state_reg <= aes_result.
  - rk_addr steps each cycle: encrypt uses r+1, decrypt uses Nr-r-1. Addresses are clamped at 0 and Nr; the key fetched after the final round is don't-care but must stay in range.
  - round_cnt = r.
  - When r==Nr, go to DONE; otherwise r <= r+1.
- aes_A/aes_B/aes_encryption/aes_finalRound are 0 outside ROUND.
- DONE: out_valid=1, out_data=state_reg, both held stable until out_ready=1. On the out_valid&&out_ready cycle, go to IDLE. out_valid drops the next cycle. No new start is accepted in the same cycle.
- Latency: accept at cycle T gives out_valid first high at T+Nr+3 (T+13 for AES-128, T+15 for AES-192, T+17 for AES-256). Throughput is one block per Nr+4 cycles with out_ready held high.
- start while busy: ignored, with no effect on the in-flight block. Inputs are sampled only on the accept cycle; changes to block_in, encrypt_in or key_size later have no effect.
- out_ready while out_valid=0: ignored.
- Decryption assumes the round-key store holds equivalent-inverse-cipher keys; the sequencer only reverses address order.

Test Plan:
- AES-128 encrypt: key 000102030405060708090a0b0c0d0e0f pre-loaded, block 00112233445566778899aabbccddeeff, out_ready=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at accept+13, exactly one cycle long.
- AES-128 decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a with the inverse key schedule -> 00112233445566778899aabbccddeeff. rk_addr sequence is 10,9,...,0. aes_finalRound is high only with round_cnt=10.
- AES-256 (key_size=2), FIPS-197 key 000102...1f, same plaintext -> 8ea2b7ca516745bfeafc49904b496089 at accept+17. aes_finalRound is high only at round 14.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid/out_data stable, start pulses ignored (start_ready=0). Raise out_ready -> IDLE next cycle, and a new start is accepted the cycle after.
- Reset at round 5 of an encryption -> next cycle busy=0, start_ready=1, all aes_* outputs 0. A following operation produces the correct result with no stale out_valid.
- key_size=3 -> behaves as AES-128 (10 rounds, latency 13). Changing block_in mid-operation does not alter the result.
